tt_um_fdc_chip: RTL and testbench

Frequency-to-digital converter (FDC) top level for the Tiny Tapeout user slot. It counts rising edges of an asynchronous input signal over a programmable gate window of system clocks and latches a 16-bit result. The result is read bytewise on the dedicated outputs, and status is reported on the bidirectional pins, which are driven permanently as outputs.

---
 rtl/fdc_pkg.sv | 28 ++
 rtl/fdc_sync_edge.sv | 35 +++
 rtl/tt_um_fdc_chip.sv | 104 ++++++++++
 tb/tb_tt_um_fdc_chip.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fdc_pkg.sv
// Shared constants and helpers for the frequency-to-digital converter.
package fdc_pkg;

    localparam int RESULT_W       = 16;
    localparam int TIMER_W        = 17;
    localparam int GATE_LOG2_BASE = 10;
    localparam int GATE_W         = 3;
    localparam int WIN_CNT_W      = 5;

    localparam int UI_FIN      = 0;
    localparam int UI_GATE_LO  = 1;
    localparam int UI_BYTE_SEL = 4;
    localparam int UI_HOLD     = 5;

    localparam int UIO_DONE   = 0;
    localparam int UIO_OVF    = 1;
    localparam int UIO_FIN_S  = 2;
    localparam int UIO_WIN_LO = 3;

    // Last timer value of a window: 2^(10+gate)-1; gate=7 wraps to all ones.
    function automatic logic [TIMER_W-1:0] win_last(input logic [GATE_W-1:0] gate);
        logic [TIMER_W:0] w;
        w = (TIMER_W + 1)'(1) << (GATE_LOG2_BASE + int'(gate));
        w = w - (TIMER_W + 1)'(1);
        return w[TIMER_W-1:0];
    endfunction

endpackage

// File: rtl/fdc_sync_edge.sv
// Two-flop synchronizer for the asynchronous fin input plus rising-edge detect.
module fdc_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic fin,
    output logic fin_s,
    output logic fin_rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    always_comb begin
        sync1_d = fin;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign fin_s    = sync2_q;
    assign fin_rise = sync2_q & ~prev_q;

endmodule

// File: rtl/tt_um_fdc_chip.sv
// FDC top: counts fin rising edges over a 2^(10+gate_sel) clock window and
// publishes a saturating 16-bit result bytewise with status on uio.
module tt_um_fdc_chip
    import fdc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // The pin keeps its legacy name but is an active-high synchronous reset.
    logic rst;
    assign rst = rst_n;

    logic unused_pins;
    assign unused_pins = &{1'b0, ena, uio_in, ui_in[7:6]};

    logic fin_s, fin_rise;

    fdc_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .fin     (ui_in[UI_FIN]),
        .fin_s   (fin_s),
        .fin_rise(fin_rise)
    );

    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [GATE_W-1:0]    gate_q, gate_d;
    logic [RESULT_W-1:0]  cnt_q, cnt_d;
    logic                 ovf_acc_q, ovf_acc_d;
    logic [RESULT_W-1:0]  result_q, result_d;
    logic                 ovf_q, ovf_d;
    logic [WIN_CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic                 done_q, done_d;

    logic                 win_end;
    logic                 cnt_sat;
    logic [RESULT_W-1:0]  cnt_fin;
    logic                 ovf_fin;

    always_comb begin
        // gate_sel is captured on the first cycle of every window; the
        // window end is never at timer 0, so gate_q is always settled.
        gate_d   = (timer_q == '0) ? ui_in[UI_GATE_LO +: GATE_W] : gate_q;
        win_end  = (timer_q == win_last(gate_q));
        cnt_sat  = (cnt_q == '1);
        cnt_fin  = (fin_rise && !cnt_sat) ? cnt_q + 1'b1 : cnt_q;
        ovf_fin  = ovf_acc_q | (fin_rise & cnt_sat);

        timer_d   = timer_q + 1'b1;
        cnt_d     = cnt_fin;
        ovf_acc_d = ovf_fin;
        result_d  = result_q;
        ovf_d     = ovf_q;
        win_cnt_d = win_cnt_q;
        done_d    = 1'b0;

        if (win_end) begin
            // An edge on the last cycle is folded into the finished window.
            timer_d   = '0;
            cnt_d     = '0;
            ovf_acc_d = 1'b0;
            if (!ui_in[UI_HOLD]) begin
                result_d  = cnt_fin;
                ovf_d     = ovf_fin;
                win_cnt_d = win_cnt_q + 1'b1;
                done_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= '0;
            gate_q    <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            win_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            gate_q    <= gate_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            win_cnt_q <= win_cnt_d;
            done_q    <= done_d;
        end
    end

    assign uo_out  = ui_in[UI_BYTE_SEL] ? result_q[15:8] : result_q[7:0];
    assign uio_out = {win_cnt_q, fin_s, ovf_q, done_q};
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_fdc_chip.sv
// Directed bench for tt_um_fdc_chip: window timing, counts, hold, saturation.
module tb_tt_um_fdc_chip;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena = 1'b1;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic       fin = 1'b0;
    logic [2:0] gate_sel = 3'd0;
    logic       byte_sel = 1'b0;
    logic       hold = 1'b0;

    int fin_half = 0;        // 0 = hold fin at fin_const, else toggle every fin_half clocks
    logic fin_const = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    assign ui_in = {2'b00, hold, byte_sel, gate_sel, fin};

    tt_um_fdc_chip dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Counts clocks (sampled at negedge) until done is seen.
    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (cyc < max) begin
            @(negedge clk);
            cyc++;
            if (uio_out[0]) return;
        end
        cyc = -1;
    endtask

    task automatic rd_result(output logic [15:0] r);
        byte_sel = 1'b0;
        #1 r[7:0] = uo_out;
        byte_sel = 1'b1;
        #1 r[15:8] = uo_out;
        byte_sel = 1'b0;
    endtask

    initial begin : fin_gen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (fin_half == 0) begin
                fin = fin_const;
                ph = 0;
            end else begin
                ph++;
                if (ph >= fin_half) begin
                    ph = 0;
                    fin = ~fin;
                end
            end
        end
    end

    initial begin : stim
        int cyc;
        int ndone;
        logic [15:0] r;
        logic [4:0]  wc;

        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_uo", {24'd0, uo_out}, 32'h00);
        chk("rst_uio", {24'd0, uio_out}, 32'h00);
        chk("rst_oe", {24'd0, uio_oe}, 32'hFF);

        rst_n = 1'b0;
        wait_done(1100, cyc);
        chk("first_done", cyc, 1024);
        chk("first_wc", {27'd0, uio_out[7:3]}, 1);
        rd_result(r);
        chk("first_res", {16'd0, r}, 0);

        // fin period 8 -> 128 edges per 1024-clock window
        fin_half = 4;
        wait_done(1100, cyc);
        wait_done(1100, cyc);
        chk("g0_period", cyc, 1024);
        byte_sel = 1'b0;
        #1 chk("g0_lo", {24'd0, uo_out}, 32'h80);
        byte_sel = 1'b1;
        #1 chk("g0_hi", {24'd0, uo_out}, 32'h00);
        byte_sel = 1'b0;
        chk("g0_ovf", {31'd0, uio_out[1]}, 0);
        chk("g0_wc", {27'd0, uio_out[7:3]}, 3);
        wait_done(1100, cyc);
        chk("wc_inc", {27'd0, uio_out[7:3]}, 4);
        @(negedge clk);
        chk("done_1cyc", {31'd0, uio_out[0]}, 0);

        // saturation: preload counter close to the top, then let 128 edges arrive
        wait_done(1100, cyc);
        force dut.cnt_q = 16'hFFFE;
        #1 release dut.cnt_q;
        wait_done(1100, cyc);
        rd_result(r);
        chk("sat_res", {16'd0, r}, 32'hFFFF);
        chk("sat_ovf", {31'd0, uio_out[1]}, 1);
        wait_done(1100, cyc);
        rd_result(r);
        chk("post_sat_res", {16'd0, r}, 32'h80);
        chk("post_sat_ovf", {31'd0, uio_out[1]}, 0);

        // hold: a window end passes with no update while fin is stopped
        wc = uio_out[7:3];
        hold = 1'b1;
        fin_half = 0;
        fin_const = 1'b0;
        ndone = 0;
        repeat (1100) begin
            @(negedge clk);
            if (uio_out[0]) ndone++;
        end
        chk("hold_nodone", ndone, 0);
        rd_result(r);
        chk("hold_res", {16'd0, r}, 32'h80);
        chk("hold_wc", {27'd0, uio_out[7:3]}, {27'd0, wc});
        hold = 1'b0;
        wait_done(1100, cyc);
        chk("unhold_done", cyc, 948);
        rd_result(r);
        chk("unhold_res", {16'd0, r}, 0);
        chk("unhold_wc", {27'd0, uio_out[7:3]}, {27'd0, wc + 5'd1});

        // constant high fin: the single rise lands in one window, the next reads 0
        fin_const = 1'b1;
        wait_done(1100, cyc);
        wait_done(1100, cyc);
        rd_result(r);
        chk("const_res", {16'd0, r}, 0);
        chk("fin_s", {31'd0, uio_out[2]}, 1);

        // gate change mid-window only affects the next window
        fin_const = 1'b0;
        fin_half = 2;
        repeat (100) @(negedge clk);
        gate_sel = 3'd2;
        wait_done(1100, cyc);
        chk("gate_cur", cyc, 924);
        wait_done(4200, cyc);
        chk("gate_next", cyc, 4096);
        rd_result(r);
        chk("g2_res", {16'd0, r}, 32'h0400);
        byte_sel = 1'b1;
        #1 chk("g2_hi", {24'd0, uo_out}, 32'h04);
        byte_sel = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
